// File: rtl/mul_accumulate_unit.sv
// mul_accumulate_unit: iterative shift-add multiply-accumulate engine.
// Computes (multiplicand * multiplier + addend) mod 2^WORD, one multiplier bit per cycle.
// The registered result and its N/Z flags are held on accumulator_o until the next completion.
// Optional feature macro: MUL_EARLY_TERM_EN. When it is defined, RUN ends as soon as the
// remaining multiplier bits are all zero. Results are the same with or without it.
//
// Handshake: start_i is sampled only in IDLE or DONE, and only when flush_i is low.
// busy_o is high for every RUN cycle. done_o is a one-cycle pulse in DONE.
// busy_o and done_o are both decoded from the state register, so they are never high together.
// flush_i returns the unit to IDLE from any state and takes priority over start_i.
// state_o exposes the FSM state for observation.
module mul_accumulate_unit #(
    parameter int WORD = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [WORD-1:0] multiplicand_i,
    input  logic [WORD-1:0] multiplier_i,
    input  logic [WORD-1:0] addend_i,
    input  logic            accumulate_en_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [WORD-1:0] accumulator_o,
    output logic            n_flag_o,
    output logic            z_flag_o,
    output logic [1:0]      state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CW = (WORD > 1) ? $clog2(WORD) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WORD - 1);

    logic [1:0]      state;
    logic [WORD-1:0] mcand;
    logic [WORD-1:0] mplier;
    logic [WORD-1:0] acc;
    logic [CW-1:0]   count;

    logic [WORD-1:0] acc_sum;
    logic [WORD-1:0] mplier_shift;
    logic            finish;
    logic            accept;

    // Per-iteration datapath values, end-of-run detection and start acceptance.
    always_comb begin
        acc_sum      = mplier[0] ? (acc + mcand) : acc;
        mplier_shift = mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
        finish       = (count == LAST_COUNT) || (mplier_shift == '0);
`else
        finish       = (count == LAST_COUNT);
`endif
        accept       = start_i && !flush_i && (state != ST_RUN);
    end

    // FSM state register. A flush returns the unit to IDLE from every state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else if (flush_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start_i) state <= ST_RUN;
                ST_RUN:  if (finish)  state <= ST_DONE;
                ST_DONE: state <= start_i ? ST_RUN : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand load on an accepted start, then one shift-add iteration per RUN cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (accept) begin
            mcand  <= multiplicand_i;
            mplier <= multiplier_i;
            acc    <= accumulate_en_i ? addend_i : '0;
            count  <= '0;
        end else if (state == ST_RUN && !flush_i) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier_shift;
            count  <= count + CW'(1);
        end
    end

    // Result and flags are captured only on the edge that enters DONE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            accumulator_o <= '0;
            n_flag_o      <= 1'b0;
            z_flag_o      <= 1'b1;
        end else if (state == ST_RUN && !flush_i && finish) begin
            accumulator_o <= acc_sum;
            n_flag_o      <= acc_sum[WORD-1];
            z_flag_o      <= (acc_sum == '0);
        end
    end

    // Status outputs are decoded from the state register only.
    always_comb begin
        busy_o  = (state == ST_RUN);
        done_o  = (state == ST_DONE);
        state_o = state;
    end

endmodule

// File: tb/tb_mul_accumulate_unit.sv
// tb_mul_accumulate_unit: directed-vector bench for mul_accumulate_unit (WORD=32).
// Honours MUL_EARLY_TERM_EN for the expected latencies.
module tb_mul_accumulate_unit;

    localparam int WORD = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;

    logic            clk_i;
    logic            rst_n_i;
    logic            start_i;
    logic            flush_i;
    logic [WORD-1:0] multiplicand_i;
    logic [WORD-1:0] multiplier_i;
    logic [WORD-1:0] addend_i;
    logic            accumulate_en_i;
    logic            busy_o;
    logic            done_o;
    logic [WORD-1:0] accumulator_o;
    logic            n_flag_o;
    logic            z_flag_o;
    logic [1:0]      state_o;

    int checks   = 0;
    int failures = 0;

    mul_accumulate_unit #(.WORD(WORD)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .flush_i        (flush_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .addend_i       (addend_i),
        .accumulate_en_i(accumulate_en_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .accumulator_o  (accumulator_o),
        .n_flag_o       (n_flag_o),
        .z_flag_o       (z_flag_o),
        .state_o        (state_o)
    );

    // Clock: 10 ns period.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Expected cycles from the accept edge to the done cycle (done in cycle N+lat).
    function automatic int exp_lat(input logic [WORD-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < WORD; i++) if (b[i]) msb = i;
        return 1 + ((msb + 1 < 1) ? 1 : msb + 1);
`else
        return WORD + 1;
`endif
    endfunction

    // Present operands and hold start_i over one rising edge (the accept edge).
    task automatic issue(input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                         input logic [WORD-1:0] c, input logic en);
        multiplicand_i  = a;
        multiplier_i    = b;
        addend_i        = c;
        accumulate_en_i = en;
        start_i         = 1'b1;
        @(posedge clk_i); #1;
        start_i         = 1'b0;
    endtask

    // Called in cycle N+1. Returns the done cycle offset, busy cycles and busy/done overlaps.
    task automatic wait_done(output int lat, output int busy_cnt, output int overlap);
        lat = 1; busy_cnt = 0; overlap = 0;
        while (lat < 200) begin
            if (busy_o && done_o) overlap++;
            if (busy_o) busy_cnt++;
            if (done_o) break;
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    // Run one operation and check latency, busy width, result and flags.
    task automatic run_check(input string name, input logic [WORD-1:0] a,
                             input logic [WORD-1:0] b, input logic [WORD-1:0] c,
                             input logic en, input logic [WORD-1:0] exp_res,
                             input logic exp_n, input logic exp_z);
        int lat, bc, ov;
        issue(a, b, c, en);
        wait_done(lat, bc, ov);
        checks++;
        if (lat !== exp_lat(b)) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat(b));
        end
        checks++;
        if (bc !== exp_lat(b) - 1) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, bc, exp_lat(b) - 1);
        end
        checks++;
        if (ov !== 0) begin
            failures++;
            $display("FAIL %s busy_done_overlap: got %0d required 0", name, ov);
        end
        checks++;
        if (accumulator_o !== exp_res) begin
            failures++;
            $display("FAIL %s result: got %08h required %08h", name, accumulator_o, exp_res);
        end
        checks++;
        if ({n_flag_o, z_flag_o} !== {exp_n, exp_z}) begin
            failures++;
            $display("FAIL %s flags_nz: got %b%b required %b%b", name, n_flag_o, z_flag_o, exp_n, exp_z);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        start_i = 1'b0; flush_i = 1'b0;
        multiplicand_i = '0; multiplier_i = '0; addend_i = '0; accumulate_en_i = 1'b0;
        idle_cycles(3);
        checks++;
        if ({busy_o, done_o, n_flag_o, z_flag_o} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_status busy,done,n,z: got %b%b%b%b required 0001", busy_o, done_o, n_flag_o, z_flag_o);
        end
        checks++;
        if (accumulator_o !== '0) begin
            failures++;
            $display("FAIL reset_result: got %08h required 00000000", accumulator_o);
        end
        checks++;
        if (state_o !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d required %0d", state_o, ST_IDLE);
        end
        rst_n_i = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_plain_mul();
        run_check("mul_7x6", 32'd7, 32'd6, 32'd100, 1'b0, 32'd42, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int dones;
        issue(32'd7, 32'd6, 32'd0, 1'b0);
        idle_cycles(1);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy_before_reset: got %b required 1", busy_o);
        end
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, n_flag_o, z_flag_o} !== 4'b0001 || accumulator_o !== '0) begin
            failures++;
            $display("FAIL midrun_reset busy,done,n,z/result: got %b%b%b%b/%08h required 0001/00000000",
                     busy_o, done_o, n_flag_o, z_flag_o, accumulator_o);
        end
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) dones++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (dones !== 0 || state_o !== ST_IDLE) begin
            failures++;
            $display("FAIL midrun_reset_no_done: got dones=%0d state=%0d required dones=0 state=%0d", dones, state_o, ST_IDLE);
        end
    endtask

    task automatic test_zero();
        run_check("mul_zero", 32'h1234_5678, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic test_mla_wrap();
        run_check("mla_wrap", 32'hFFFF_FFFF, 32'd2, 32'd3, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        run_check("mla_neg", 32'h8000_0000, 32'd1, 32'd0, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
    endtask

    // The previous result is 0x80000000 (N=1) and must survive the flushed run.
    task automatic test_flush();
        int dones;
        issue(32'd3, 32'h8000_0001, 32'd0, 1'b0);
        idle_cycles(9);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (state_o !== ST_IDLE || busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_to_idle: got state=%0d busy=%b done=%b required state=%0d busy=0 done=0", state_o, busy_o, done_o, ST_IDLE);
        end
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        checks++;
        if (state_o !== ST_IDLE || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_dropped: got state=%0d busy=%b required state=%0d busy=0", state_o, busy_o, ST_IDLE);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o || busy_o) dones++;
            @(posedge clk_i); #1;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL flush_no_activity: got %0d active cycles required 0", dones);
        end
        checks++;
        if (accumulator_o !== 32'h8000_0000 || {n_flag_o, z_flag_o} !== 2'b10) begin
            failures++;
            $display("FAIL flush_result_kept: got %08h nz=%b%b required 80000000 nz=10", accumulator_o, n_flag_o, z_flag_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, ov;
        issue(32'd5, 32'd5, 32'd0, 1'b0);
        wait_done(lat, bc, ov);
        checks++;
        if (lat !== exp_lat(32'd5) || accumulator_o !== 32'd25) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d result=%0d required lat=%0d result=25", lat, accumulator_o, exp_lat(32'd5));
        end
        issue(32'd3, 32'd3, 32'd0, 1'b0);
        checks++;
        if (busy_o !== 1'b1 || state_o !== ST_RUN) begin
            failures++;
            $display("FAIL b2b_restart: got busy=%b state=%0d required busy=1 state=%0d", busy_o, state_o, ST_RUN);
        end
        wait_done(lat, bc, ov);
        checks++;
        if (lat !== exp_lat(32'd3)) begin
            failures++;
            $display("FAIL b2b_second_latency: got %0d required %0d", lat, exp_lat(32'd3));
        end
        checks++;
        if (accumulator_o !== 32'd9 || {n_flag_o, z_flag_o} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_second_result: got %0d nz=%b%b required 9 nz=00", accumulator_o, n_flag_o, z_flag_o);
        end
        idle_cycles(2);
        checks++;
        if (state_o !== ST_IDLE || done_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_return_idle: got state=%0d done=%b required state=%0d done=0", state_o, done_o, ST_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_plain_mul();
        test_reset_mid_run();
        test_zero();
        test_mla_wrap();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_accumulate_unit.md
# mul_accumulate_unit

Iterative shift-add multiply-accumulate engine for the execute stage. It is the producing end of the ALU wrapper's `accumulator_i` operand. It accepts two WORD operands plus an optional addend, computes `(multiplicand × multiplier + addend) mod 2^WORD` over multiple cycles, and presents the registered result and its N/Z flags on `accumulator_o`. The ALU selects that value with `FROM_ACCUMULATOR`. A start/busy/done handshake lets the hazard unit stall the pipeline while the unit runs.

## Interface
- `WORD`, default 32: operand and result width (from GENERAL_DEFS).
- `clk_i` input, 1: clock, rising edge.
- `rst_n_i` input, 1: asynchronous, active-low reset.
- `start_i` input, 1: request a new operation; sampled in IDLE or DONE.
- `flush_i` input, 1: pipeline flush; aborts any operation.
- `multiplicand_i` input, WORD: operand A.
- `multiplier_i` input, WORD: operand B.
- `addend_i` input, WORD: accumulate term (MLA).
- `accumulate_en_i` input, 1: 1 = add `addend_i`; 0 = plain MUL.
- `busy_o` output, 1: high while in RUN.
- `done_o` output, 1: single-cycle completion pulse.
- `accumulator_o` output, WORD: last completed result, held until the next completion.
- `n_flag_o` output, 1: `accumulator_o[WORD-1]`, registered with the result.
- `z_flag_o` output, 1: `accumulator_o == 0`, registered with the result.

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - `start_i=1 && flush_i=0` → RUN.
  - On that edge, load `mcand=multiplicand_i`, `mplier=multiplier_i`, `acc = accumulate_en_i ? addend_i : 0`, `count=0`.
- RUN, one iteration per edge:
  - If `mplier[0]`, then `acc += mcand`. The sum is truncated to WORD bits, so carry out is discarded.
  - Then `mcand <<= 1`, `mplier >>= 1`, `count++`.
  - After the iteration with `count==WORD-1`, go to DONE.
- DONE entry edge: `accumulator_o <= acc`, `n_flag_o <= acc[WORD-1]`, `z_flag_o <= (acc==0)`.
- DONE lasts one cycle, with `done_o=1`.
  - `start_i=1 && flush_i=0` in DONE → RUN, with operands loaded as in IDLE (back-to-back).
  - Otherwise → IDLE.
- `start_i` during RUN is ignored.
- Operands are unsigned.
- `flush_i=1` in any state → IDLE on the next edge.
  - A flush in DONE still completes the `done_o` pulse already being shown.
  - A flush in RUN produces no `done_o`, and `accumulator_o`/flags keep their previous values.
  - When `flush_i` and `start_i` are high together, flush wins and the start is dropped.
- Reset, asynchronous and active-low: state IDLE, `busy_o=0`, `done_o=0`, `accumulator_o=0`, `n_flag_o=0`, `z_flag_o=1`, internal registers 0.
  - Reset mid-RUN discards the operation.

## Timing
- If `start_i` is accepted in cycle N:
  - RUN occupies cycles N+1 to N+WORD, so `busy_o=1` for exactly WORD cycles.
  - `done_o=1` in cycle N+WORD+1.
  - `accumulator_o` shows the new value from cycle N+WORD+1 onward.
- `busy_o` and `done_o` are never high in the same cycle.
- Maximum throughput is one result per WORD+1 cycles (start accepted in the DONE cycle).
- Outputs are registered only, with no combinational input-to-output path.

## Configuration
- Macro name: `MUL_EARLY_TERM_EN`.
- Defined:
  - In RUN, if the shifted value of `mplier` (after this edge's iteration) is 0, go to DONE on this edge instead of continuing.
  - With `mplier` in RUN being `multiplier_i` at start, `done_o` asserts in cycle N+1+max(1, msb+1), where msb is the index of the highest set bit of `multiplier_i`.
  - `busy_o` lasts max(1, msb+1) cycles.
  - `multiplier_i=0` gives `done_o` in N+2.
  - Results are identical to the non-early-termination build.
- Undefined: fixed latency of WORD+1 cycles, as in Timing.

## Test plan
- Reset sequence:
  - Stimulus: assert `rst_n_i=0` mid-RUN, then release.
  - Required response: immediately `busy_o=0`, `accumulator_o=0`, `z_flag_o=1`, `n_flag_o=0`; no `done_o` afterward.
- Plain multiply:
  - Stimulus: MUL `7 × 6` with `accumulate_en_i=0`, started in cycle N.
  - Required response: `done_o` in N+33 (N+4 with `MUL_EARLY_TERM_EN`), `accumulator_o=42`, N=0, Z=0.
- Multiply-accumulate with wrap:
  - Stimulus: MLA `0xFFFFFFFF × 2 + 3`.
  - Required response: `accumulator_o=0x00000001`; plus `0x80000000 × 1 + 0` gives N=1.
- Zero result:
  - Stimulus: MUL `0x12345678 × 0` with `accumulate_en_i=0`.
  - Required response: `accumulator_o=0`, Z=1; `done_o` in N+2 with early-termination, N+33 without.
- Flush and restart:
  - Stimulus: `flush_i` in cycle N+10 of a run, then start with `start_i` and `flush_i` high together.
  - Required response: no `done_o`, `accumulator_o` unchanged, IDLE at N+11; the simultaneous start is dropped.
- Back-to-back operations:
  - Stimulus: `start_i` held high through the DONE cycle of `5 × 5`, with the operands for `3 × 3` on the inputs.
  - Required response: first `done_o` gives 25; RUN restarts on the next edge; second `done_o` gives 9, exactly WORD+1 cycles later (fixed-latency build).
